// File: rtl/tpu_host_pkg.sv
// Shared definitions for the TPU host controller: FSM state encoding,
// fixed TPU bus address map and a word-address helper.
package tpu_host_pkg;

    // Controller states, in the order a job walks through them
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_A  = 4'd1,
        ST_LOAD_B  = 4'd2,
        ST_LOAD_C  = 4'd3,
        ST_KICK    = 4'd4,
        ST_WAIT    = 4'd5,
        ST_RD_ADDR = 4'd6,
        ST_RD_OUT  = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    // TPU bus address map (byte addresses, 8-byte words)
    localparam logic [15:0] ADDR_A_BASE = 16'h0100;
    localparam logic [15:0] ADDR_B_BASE = 16'h0200;
    localparam logic [15:0] ADDR_C_BASE = 16'h0300;
    localparam logic [15:0] ADDR_KICK   = 16'h0400;

    // log2 of the word size in bytes
    localparam int WORD_SHIFT = 3;

    // Byte address of word idx inside a region starting at base
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [15:0] idx);
        return base + (idx << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/tpu_host_ctrl.sv
// TPU host controller: streams A, B and optionally C operand words onto the
// TPU bus, kicks the multiply, waits for the array to drain, then reads the
// 2*DIM C words back and offers them on the result stream.
//
// Handshakes: a stream word moves on a rising edge where valid and ready are
// both high. The sender holds data stable while valid is high and ready low;
// ready never depends on valid. Here in_ready is high in every load state and
// out_valid is high only in RD_OUT, with out_data held in a register.
module tpu_host_ctrl
    import tpu_host_pkg::*;
#(
    parameter int DIM         = 8,
    parameter int ADDRW       = 16,
    parameter int DATAW       = 64,
    parameter int WAIT_CYCLES = 3 * DIM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load_c,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] tpu_addr,
    output logic             tpu_r_w,
    output logic [DATAW-1:0] tpu_wdata,
    input  logic [DATAW-1:0] tpu_rdata,
    output logic [3:0]       dbg_state
);

    // Word counter must reach 2*DIM, wait counter must reach WAIT_CYCLES
    localparam int KW = $clog2(2 * DIM + 1);
    localparam int WW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [KW-1:0] K_LAST_AB = KW'(DIM - 1);
    localparam logic [KW-1:0] K_LAST_C  = KW'(2 * DIM - 1);
    localparam logic [WW-1:0] W_LAST    = WW'(WAIT_CYCLES - 1);

    state_t           r_state;
    logic             r_load_c;
    logic [KW-1:0]    r_k;
    logic [WW-1:0]    r_wait;
    logic [DATAW-1:0] r_out_data;

    logic             w_is_load;
    logic             w_beat;
    logic [15:0]      w_base;
    logic [15:0]      w_word_addr;

    // Region base for the current state and the address of word k in it
    always_comb begin
        w_base = ADDR_A_BASE;
        case (r_state)
            ST_LOAD_B:                        w_base = ADDR_B_BASE;
            ST_LOAD_C, ST_RD_ADDR, ST_RD_OUT: w_base = ADDR_C_BASE;
            default:                          w_base = ADDR_A_BASE;
        endcase
        w_word_addr = word_addr(w_base, 16'(r_k));
    end

    assign w_is_load = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B) ||
                       (r_state == ST_LOAD_C);
    assign w_beat    = w_is_load && in_valid;

    // Job sequencer: state, word counter, wait counter, latched load_c, read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_load_c   <= 1'b0;
            r_k        <= '0;
            r_wait     <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_load_c <= load_c;
                        r_k      <= '0;
                        r_state  <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (in_valid) begin
                        if (r_k == K_LAST_AB) begin
                            r_k     <= '0;
                            r_state <= ST_LOAD_B;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        if (r_k == K_LAST_AB) begin
                            r_k     <= '0;
                            r_state <= r_load_c ? ST_LOAD_C : ST_KICK;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                ST_LOAD_C: begin
                    if (in_valid) begin
                        if (r_k == K_LAST_C) begin
                            r_k     <= '0;
                            r_state <= ST_KICK;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                ST_KICK: begin
                    r_wait  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == W_LAST) begin
                        r_wait  <= '0;
                        r_k     <= '0;
                        r_state <= ST_RD_ADDR;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                ST_RD_ADDR: begin
                    r_out_data <= tpu_rdata;
                    r_state    <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (out_ready) begin
                        if (r_k == K_LAST_C) begin
                            r_k     <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_k     <= r_k + KW'(1);
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    r_load_c <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus drive: write beats, the kick write and C reads; idle value elsewhere
    always_comb begin
        tpu_addr  = '0;
        tpu_r_w   = 1'b0;
        tpu_wdata = '0;
        if (w_beat) begin
            tpu_r_w   = 1'b1;
            tpu_addr  = ADDRW'(w_word_addr);
            tpu_wdata = in_data;
        end else if (r_state == ST_KICK) begin
            tpu_r_w  = 1'b1;
            tpu_addr = ADDRW'(ADDR_KICK);
        end else if ((r_state == ST_RD_ADDR) || (r_state == ST_RD_OUT)) begin
            tpu_addr = ADDRW'(w_word_addr);
        end
    end

    assign in_ready  = w_is_load;
    assign out_valid = (r_state == ST_RD_OUT);
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule
